// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: holding register, status flags and ack.
// master = the receiver that produces bytes, slave = the bus-side logic that consumes them.
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output data,
        output data_valid,
        output frame_err,
        output overrun,
        output busy,
        input  ack
    );

    modport slave (
        input  data,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM, valid/ack holding
// register with sticky overrun and a one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int CTR_W        = 17
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CTR_W-1:0] FULL_CNT = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CTR_W-1:0] HALF_CNT = CTR_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_s;

    state_t           state;
    state_t           state_n;
    logic [CTR_W-1:0] ctr;
    logic [CTR_W-1:0] ctr_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shift;
    logic [7:0]       shift_n;

    logic             deliver;
    logic             drop;
    logic             ferr_n;

    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;

    // Synchroniser flops reset to the idle line level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its source.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ctr     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            ctr     <= ctr_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n   = state;
        ctr_n     = ctr;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        deliver   = 1'b0;
        drop      = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            S_IDLE: begin
                ctr_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end

            // Half a bit into the start bit: a line that is high again was only a glitch.
            S_START: begin
                if (ctr == HALF_CNT) begin
                    ctr_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                    end
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end

            S_DATA: begin
                if (ctr == FULL_CNT) begin
                    ctr_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end

            // An ack in the same cycle frees the holding register in time for the new byte.
            S_STOP: begin
                if (ctr == FULL_CNT) begin
                    ctr_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
                        if (!valid_q || bus.ack) begin
                            deliver = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    ctr_n = ctr + 1'b1;
                end
            end

            // Wait out a held-low line so its tail is not taken as a fresh start bit.
            S_BREAK: begin
                ctr_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
                ctr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= ferr_n;

            if (deliver) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (bus.ack) begin
                valid_q <= 1'b0;
            end

            if (drop) begin
                ovr_q <= 1'b1;
            end else if (bus.ack) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart to the baud generator and the transmit path.
- It samples the asynchronous serial line with an internal bit-period counter and recovers bytes LSB-first at mid-bit.
- It presents each byte through a valid/ack holding register to the bus-side logic, e.g. the MIPS UART peripheral register block.
- Framing errors and overruns are flagged.

Parameters:
- CLKS_PER_BIT, 10417: clk cycles per bit (100 MHz / 9600 bps). Legal range 4..131071.
- CTR_W, 17: width of the bit-period counter. Must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- rx  in  1  serial line, asynchronous to clk, idle high
- ack  in  1  consumer acknowledges data; clears data_valid
- data  out  8  last received byte, stable while data_valid=1
- data_valid  out  1  level, set when a byte is delivered, cleared by ack
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  sticky: byte completed while data_valid=1; cleared by ack
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - data=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, counter=0, bit index=0, synchroniser flops=1.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Input synchroniser: rx passes through 2 flops giving rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rx_s=0: go to START, counter=0.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division), then sample.
  - rx_s=0: go to DATA, counter=0, bit index=0.
  - rx_s=1: glitch; return to IDLE with no outputs.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into shift[bit index], LSB first.
  - On sample, counter=0 and bit index increments.
  - After bit index 7 is sampled, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - rx_s=1, and data_valid=0 or ack=1 that cycle: on the next edge data<=shift, data_valid<=1; go to IDLE.
  - rx_s=1, data_valid=1 and ack=0: overrun<=1, data keeps the old byte, the new byte is dropped; go to IDLE.
  - rx_s=0: frame_err pulses for exactly 1 cycle, nothing is delivered; go to BREAK.
- BREAK: remain until rx_s=1, then go to IDLE. This prevents false starts during a line break.
- ack:
  - ack=1 in any cycle clears data_valid and overrun on the next edge.
  - Delivery and ack in the same cycle: the new byte loads, data_valid stays 1, overrun stays 0.
  - ack with data_valid=0 has no effect.
- Latency: data_valid rises 1 cycle after the stop-bit sample edge.
  - The stop sample occurs ~9.5*CLKS_PER_BIT + 2 cycles after the rx falling edge.
- Counter arithmetic:
  - Unsigned CTR_W bits; reset to 0 at every sample, never wraps.
  - Comparisons are equality against CLKS_PER_BIT-1 or CLKS_PER_BIT/2-1, truncated to CTR_W.
- busy=1 in START, DATA, STOP and BREAK.
- ack is ignored by the FSM and never stalls reception.
- Back-to-back frames: a start bit immediately following a stop bit is detected from IDLE. Resynchronisation happens on every start edge.

Test Plan (CLKS_PER_BIT=16):
- Single frame 0xA5, ideal timing, ack pulsed 5 cycles after data_valid → data=0xA5, data_valid=1 until the cycle after ack, frame_err=0, overrun=0.
- Glitch: rx low for 4 cycles then high → FSM returns to IDLE, busy falls, data_valid stays 0.
- Stop bit driven 0 with byte 0x3C, rx held low 40 more cycles then high → single 1-cycle frame_err pulse, data_valid=0, busy=1 until rx high + 2 cycles.
- Bytes 0x11 then 0x22 back-to-back with no ack → data=0x11, data_valid=1, overrun=1. A following ack clears both flags.
- Byte 0x5A sent at ±4 % bit-rate error → data=0x5A. Also drive ack in the exact delivery cycle of the second byte 0x6B → data=0x6B, data_valid=1, overrun=0.
- rst=0 asserted mid-DATA for one cycle, then a clean frame 0x81 → no output from the aborted frame, data=0x81 delivered, all outputs 0 during reset.
